// File: rtl/conv33_window_gen.sv
// rtl/conv33_window_gen.sv - raster pixel stream to 3x3 sliding window generator
//
// Purpose: turns a row-major pixel stream (one pixel per beat) into 3x3
// "valid" convolution windows, (IMG_WIDTH-2)*(IMG_HEIGHT-2) per frame.
// Ports:
//   clk, rst                : clock (rising edge), asynchronous active-low reset
//   pix_valid/pix_ready     : input pixel handshake, pix_data carries the pixel
//   out_valid/out_ready     : output window handshake
//   data_out_R_C            : window element, R=0 oldest row, C=0 oldest column
//   frame_done              : one-cycle pulse after the last pixel of a frame

module conv33_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out_0_0,
    output logic [DATA_WIDTH-1:0] data_out_0_1,
    output logic [DATA_WIDTH-1:0] data_out_0_2,
    output logic [DATA_WIDTH-1:0] data_out_1_0,
    output logic [DATA_WIDTH-1:0] data_out_1_1,
    output logic [DATA_WIDTH-1:0] data_out_1_2,
    output logic [DATA_WIDTH-1:0] data_out_2_0,
    output logic [DATA_WIDTH-1:0] data_out_2_1,
    output logic [DATA_WIDTH-1:0] data_out_2_2,
    output logic                  frame_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // linebuf0 holds the previous row, linebuf1 the row before that
    logic [DATA_WIDTH-1:0] linebuf0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] linebuf1 [IMG_WIDTH];

    logic [DATA_WIDTH-1:0] win [3][3];

    logic out_valid_r;
    logic frame_done_r;
    logic pix_acc;
    logic win_load;
    logic col_wrap;
    logic at_last;

    // A held window blocks input: accepting a pixel would shift the window.
    assign pix_ready = !out_valid_r || out_ready;
    assign pix_acc   = pix_valid && pix_ready;
    assign col_wrap  = (col == COL_LAST);
    assign at_last   = col_wrap && (row == ROW_LAST);
    // c>=2 guarantees the two older window columns were shifted in this row.
    assign win_load  = pix_acc && (row >= ROW_TWO) && (col >= COL_TWO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col          <= '0;
            row          <= '0;
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            frame_done_r <= pix_acc && at_last;

            if (pix_acc) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= linebuf1[col];
                win[1][2] <= linebuf0[col];
                win[2][2] <= pix_data;

                if (col_wrap) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (win_load) begin
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Line buffers carry no reset: rows 0-1 never produce windows, so their
    // power-up contents are never observed.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            linebuf1[col] <= linebuf0[col];
            linebuf0[col] <= pix_data;
        end
    end

    assign out_valid    = out_valid_r;
    assign frame_done   = frame_done_r;
    assign data_out_0_0 = win[0][0];
    assign data_out_0_1 = win[0][1];
    assign data_out_0_2 = win[0][2];
    assign data_out_1_0 = win[1][0];
    assign data_out_1_1 = win[1][1];
    assign data_out_1_2 = win[1][2];
    assign data_out_2_0 = win[2][0];
    assign data_out_2_1 = win[2][1];
    assign data_out_2_2 = win[2][2];

endmodule

// File: tb/tb_conv33_window_gen.sv
// tb/tb_conv33_window_gen.sv - self-checking bench for conv33_window_gen
module tb_conv33_window_gen;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [DW-1:0] pix_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          frame_done;
    logic [DW-1:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;

    conv33_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out_0_0(d00), .data_out_0_1(d01), .data_out_0_2(d02),
        .data_out_1_0(d10), .data_out_1_1(d11), .data_out_1_2(d12),
        .data_out_2_0(d20), .data_out_2_1(d21), .data_out_2_2(d22),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    wire [71:0] win_now = {d00, d01, d02, d10, d11, d12, d20, d21, d22};

    // ---------------- reference model: stores the frame, cuts windows out of it
    logic [DW-1:0] img [H][W];
    int            pos_r = 0, pos_c = 0;
    logic [71:0]   exp_q[$];
    logic [71:0]   log_q[$];
    logic          exp_fd = 1'b0;
    logic          held_prev = 1'b0;
    logic [71:0]   held_val = '0;
    int            fd_count = 0;
    int            pr_low = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_out_valid", {71'd0, out_valid}, 72'd0);
            chk("reset_window", win_now, 72'd0);
            chk("reset_frame_done", {71'd0, frame_done}, 72'd0);
            exp_q.delete();
            pos_r = 0; pos_c = 0;
            exp_fd = 1'b0;
            held_prev = 1'b0;
        end else begin
            chk("pix_ready", {71'd0, pix_ready}, {71'd0, (!out_valid || out_ready)});
            chk("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
            chk("out_valid", {71'd0, out_valid}, {71'd0, exp_q.size() != 0});
            if (frame_done) fd_count++;
            if (!pix_ready) pr_low++;
            if (held_prev) chk("held_window", win_now, held_val);
            held_prev = out_valid && !out_ready;
            held_val  = win_now;
            if (out_valid && out_ready && exp_q.size() != 0) begin
                chk("window", win_now, exp_q[0]);
                log_q.push_back(win_now);
                void'(exp_q.pop_front());
            end
            exp_fd = 1'b0;
            if (pix_valid && pix_ready) begin
                img[pos_r][pos_c] = pix_data;
                if (pos_r >= 2 && pos_c >= 2) begin
                    exp_q.push_back({img[pos_r-2][pos_c-2], img[pos_r-2][pos_c-1], img[pos_r-2][pos_c],
                                     img[pos_r-1][pos_c-2], img[pos_r-1][pos_c-1], img[pos_r-1][pos_c],
                                     img[pos_r][pos_c-2],   img[pos_r][pos_c-1],   img[pos_r][pos_c]});
                end
                if (pos_r == H-1 && pos_c == W-1) exp_fd = 1'b1;
                pos_c++;
                if (pos_c == W) begin
                    pos_c = 0;
                    pos_r = (pos_r == H-1) ? 0 : pos_r + 1;
                end
            end
        end
    end

    // ---------------- consumer: 0 always ready, 1 random, 2 scripted 3-cycle stall
    int rmode = 0;
    bit bp_arm = 1'b0;
    int bp_left = 0;

    always @(posedge clk) begin
        #1;
        if (rmode == 1) begin
            out_ready = ($urandom_range(0, 2) != 0);
        end else if (rmode == 2) begin
            if (bp_arm && out_valid) begin
                out_ready = 1'b0;
                bp_left = 3;
                bp_arm = 1'b0;
            end else if (bp_left > 0) begin
                bp_left--;
                if (bp_left == 0) out_ready = 1'b1;
            end
        end else begin
            out_ready = 1'b1;
        end
    end

    // ---------------- stimulus
    int gap_mode = 0;   // 0 none, 1 toggle, 2 random gaps

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [DW-1:0] v);
        bit acc;
        int budget;
        if (gap_mode == 1) begin
            pix_valid = 1'b0;
            cycle();
        end else if (gap_mode == 2 && $urandom_range(0, 2) == 0) begin
            pix_valid = 1'b0;
            repeat ($urandom_range(1, 4)) cycle();
        end
        pix_valid = 1'b1;
        pix_data  = v;
        budget = 0;
        acc = 1'b0;
        while (!acc && budget < 1000) begin
            @(negedge clk);
            acc = pix_ready;
            cycle();
            budget++;
        end
        if (!acc) chk("pixel_accept_timeout", 72'd0, 72'd1);
    endtask

    task automatic send_frame(input int base, input bit constant);
        for (int i = 0; i < W*H; i++) begin
            send_pixel(constant ? DW'(base) : DW'(base + i));
        end
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        rmode = 0;
        repeat (6) cycle();
    endtask

    task automatic cmp_basic(input string name);
        chk({name, "_count"}, 72'(log_q.size()), 72'(basic.size()));
        for (int i = 0; i < basic.size() && i < log_q.size(); i++)
            chk(name, log_q[i], basic[i]);
    endtask

    logic [71:0] basic[$];
    int fd0;

    initial begin
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        chk("rst_pix_ready", {71'd0, pix_ready}, 72'd1);
        chk("rst_out_valid", {71'd0, out_valid}, 72'd0);
        chk("rst_frame_done", {71'd0, frame_done}, 72'd0);
        chk("rst_window", win_now, 72'd0);

        // basic windowing
        log_q.delete();
        send_frame(1, 1'b0);
        drain();
        chk("basic_count", 72'(log_q.size()), 72'd6);
        if (log_q.size() == 6) begin
            chk("basic_first", log_q[0], 72'h010203_060708_0B0C0D);
            chk("basic_last",  log_q[5], 72'h08090A_0D0E0F_121314);
        end
        basic = log_q;

        // backpressure on the first window
        log_q.delete();
        pr_low = 0;
        bp_arm = 1'b1;
        rmode = 2;
        send_frame(1, 1'b0);
        drain();
        chk("bp_stall_cycles", 72'(pr_low), 72'd3);
        cmp_basic("bp_window");

        // input gaps: toggle then random
        gap_mode = 1;
        log_q.delete();
        send_frame(1, 1'b0);
        drain();
        cmp_basic("toggle_window");
        gap_mode = 2;
        log_q.delete();
        send_frame(1, 1'b0);
        drain();
        cmp_basic("gap_window");
        gap_mode = 0;

        // back-to-back frames
        log_q.delete();
        fd0 = fd_count;
        send_frame(1, 1'b0);
        send_frame(101, 1'b0);
        drain();
        chk("b2b_frame_done", 72'(fd_count - fd0), 72'd2);
        chk("b2b_count", 72'(log_q.size()), 72'd12);
        if (log_q.size() == 12)
            chk("b2b_second_first", log_q[6], 72'h656667_6A6B6C_6F7071);

        // reset mid-frame
        for (int i = 0; i < 12; i++) send_pixel(DW'(i + 1));
        pix_valid = 1'b0;
        rst = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        log_q.delete();
        send_frame(1, 1'b0);
        drain();
        cmp_basic("post_reset_window");

        // extreme values
        log_q.delete();
        fd0 = fd_count;
        send_frame(255, 1'b1);
        send_frame(0, 1'b1);
        drain();
        chk("extreme_frame_done", 72'(fd_count - fd0), 72'd2);
        chk("extreme_count", 72'(log_q.size()), 72'd12);
        for (int i = 0; i < log_q.size(); i++)
            chk("extreme_window", log_q[i], (i < 6) ? {9{8'hFF}} : 72'd0);

        // randomized: random pixels, random gaps, random consumer
        gap_mode = 2;
        rmode = 1;
        log_q.delete();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < W*H; i++) send_pixel(DW'($urandom_range(0, 255)));
        end
        pix_valid = 1'b0;
        gap_mode = 0;
        drain();
        chk("random_count", 72'(log_q.size()), 72'd24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
